// File: rtl/cy_control_reg_pulse.sv
// CPU-writable control register driving up to eight fabric nets. Each bit holds a
// written level or emits a fixed-width self-clearing pulse, with optional retiming.
module cy_control_reg_pulse #(
   parameter int         NumOutputs   = 8,
   parameter logic [7:0] DefaultValue = 8'h00,
   parameter logic [7:0] PulseMask    = 8'h00,
   parameter int         PulseWidth   = 1,
   parameter bit         SyncMode     = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   // cpu_wr qualifies cpu_wdata for exactly the cycle it is high; every such
   // cycle is a complete write and there is no back-pressure toward the bus.
   input  logic       cpu_wr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       control_0,
   output logic       control_1,
   output logic       control_2,
   output logic       control_3,
   output logic       control_4,
   output logic       control_5,
   output logic       control_6,
   output logic       control_7,
   output logic [7:0] control_bus,
   output logic       pulse_active
);

   localparam logic [8:0] LiveFull    = (9'd1 << NumOutputs) - 9'd1;
   localparam logic [7:0] LiveMask    = LiveFull[7:0];
   localparam logic [7:0] ActivePulse = PulseMask & LiveMask;
   // Pulse bits never come out of reset high: they would have no counter behind them.
   localparam logic [7:0] ResetValue  = DefaultValue & LiveMask & ~ActivePulse;
   localparam logic [3:0] Width4      = 4'(PulseWidth);

   logic [7:0]      ctrl;
   logic [7:0]      ctrl_nxt;
   logic [7:0][3:0] cnt;
   logic [7:0][3:0] cnt_nxt;
   logic [7:0]      out_q;
   logic [7:0]      out_vec;

   always_comb begin
      ctrl_nxt = ctrl;
      cnt_nxt  = cnt;
      for (int i = 0; i < 8; i++) begin
         if (!LiveMask[i]) begin
            ctrl_nxt[i] = 1'b0;
            cnt_nxt[i]  = 4'd0;
         end else if (ActivePulse[i]) begin
            // A write of 1 reloads the counter, so a retrigger extends without a gap.
            if (cpu_wr && cpu_wdata[i]) begin
               ctrl_nxt[i] = 1'b1;
               cnt_nxt[i]  = Width4;
            end else if (cnt[i] != 4'd0) begin
               cnt_nxt[i]  = cnt[i] - 4'd1;
               ctrl_nxt[i] = (cnt[i] > 4'd1);
            end
         end else if (cpu_wr) begin
            ctrl_nxt[i] = cpu_wdata[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl  <= ResetValue;
         cnt   <= '0;
         out_q <= ResetValue;
      end else begin
         ctrl  <= ctrl_nxt;
         cnt   <= cnt_nxt;
         out_q <= ctrl;
      end
   end

   always_comb begin
      pulse_active = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pulse_active = pulse_active | (cnt[i] != 4'd0);
      end
   end

   assign out_vec     = SyncMode ? out_q : ctrl;
   assign cpu_rdata   = ctrl;
   assign control_bus = out_vec;
   assign control_0   = out_vec[0];
   assign control_1   = out_vec[1];
   assign control_2   = out_vec[2];
   assign control_3   = out_vec[3];
   assign control_4   = out_vec[4];
   assign control_5   = out_vec[5];
   assign control_6   = out_vec[6];
   assign control_7   = out_vec[7];

endmodule

// File: tb/tb_cy_control_reg_pulse.sv
// Bench for cy_control_reg_pulse: six differently parameterised instances, directed
// vectors with hand-computed expectations, queue-based scoreboard and monitor.
module tb_cy_control_reg_pulse;

   localparam int NUM_D = 6;
   // d0 reset/pulse-mask default, d1 level, d2 pulse w3, d3 retrigger w4,
   // d4 five live bits, d5 retimed output with pulse bit 0
   localparam int         P_NUM  [NUM_D] = '{8, 8, 8, 8, 5, 8};
   localparam logic [7:0] P_DEF  [NUM_D] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h42};
   localparam logic [7:0] P_MASK [NUM_D] = '{8'h01, 8'h00, 8'h80, 8'h80, 8'h00, 8'h01};
   localparam int         P_WID  [NUM_D] = '{1, 1, 3, 4, 1, 3};
   localparam bit         P_SYNC [NUM_D] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   logic             clock;
   logic [NUM_D-1:0] rst;
   logic [NUM_D-1:0] wr;
   logic [7:0]       wdata [NUM_D];
   logic [7:0]       rdata [NUM_D];
   logic [7:0]       bus   [NUM_D];
   logic [7:0]       cbits [NUM_D];
   logic [NUM_D-1:0] pa;

   logic [19:0] exp_q [$];
   int          checks;
   int          fails;

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < NUM_D; g++) begin : g_dut
      logic b0, b1, b2, b3, b4, b5, b6, b7;
      cy_control_reg_pulse #(
         .NumOutputs  (P_NUM[g]),
         .DefaultValue(P_DEF[g]),
         .PulseMask   (P_MASK[g]),
         .PulseWidth  (P_WID[g]),
         .SyncMode    (P_SYNC[g])
      ) u_dut (
         .clock       (clock),
         .reset       (rst[g]),
         .cpu_wr      (wr[g]),
         .cpu_wdata   (wdata[g]),
         .cpu_rdata   (rdata[g]),
         .control_0   (b0),
         .control_1   (b1),
         .control_2   (b2),
         .control_3   (b3),
         .control_4   (b4),
         .control_5   (b5),
         .control_6   (b6),
         .control_7   (b7),
         .control_bus (bus[g]),
         .pulse_active(pa[g])
      );
      assign cbits[g] = {b7, b6, b5, b4, b3, b2, b1, b0};
   end

   // driver: one vector per cycle; expectation describes state after the next edge
   task automatic step(input logic [2:0] sel, input logic r, input logic w,
                       input logic [7:0] d, input logic [7:0] eb,
                       input logic [7:0] er, input logic ep);
      @(negedge clock);
      rst = '0;
      wr  = '0;
      for (int k = 0; k < NUM_D; k++) wdata[k] = 8'h00;
      rst[sel]   = r;
      wr[sel]    = w;
      wdata[sel] = d;
      exp_q.push_back({sel, eb, er, ep});
   endtask

   task automatic chk(input string name, input logic [2:0] sel,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut=%0d got=%h expected=%h at %0t", name, sel, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   initial begin
      logic [19:0] e;
      logic [2:0]  s;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            s = e[19:17];
            chk("control_bus", s, bus[s], e[16:9]);
            chk("control_n", s, cbits[s], e[16:9]);
            chk("cpu_rdata", s, rdata[s], e[8:1]);
            chk("pulse_active", s, {7'd0, pa[s]}, {7'd0, e[0]});
         end
      end
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog timeout at %0t", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      checks = 0;
      fails  = 0;
      rst    = '1;
      wr     = '0;
      for (int k = 0; k < NUM_D; k++) wdata[k] = 8'h00;
      repeat (2) @(negedge clock);

      // d0: reset wins over write; default A5 with pulse bit 0 gives A4
      step(3'd0, 1'b1, 1'b1, 8'hFF, 8'hA4, 8'hA4, 1'b0);
      step(3'd0, 1'b0, 1'b0, 8'h00, 8'hA4, 8'hA4, 1'b0);
      step(3'd0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1);
      step(3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      step(3'd0, 1'b0, 1'b1, 8'hA4, 8'hA4, 8'hA4, 1'b0);

      // d1: level bits
      step(3'd1, 1'b0, 1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0);
      step(3'd1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0);
      step(3'd1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b0);
      step(3'd1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      step(3'd1, 1'b0, 1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);

      // d2: bit 7 pulse, width 3; write 0 mid-pulse ignored
      step(3'd2, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 1'b1);
      step(3'd2, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
      step(3'd2, 1'b0, 1'b1, 8'h00, 8'h80, 8'h80, 1'b1);
      step(3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      step(3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      // d3: retrigger two cycles in, width 4 -> six high cycles
      step(3'd3, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 1'b1);
      step(3'd3, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
      step(3'd3, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 1'b1);
      step(3'd3, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
      step(3'd3, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
      step(3'd3, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
      step(3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      step(3'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      // d4: five live bits
      step(3'd4, 1'b0, 1'b1, 8'hFF, 8'h1F, 8'h1F, 1'b0);
      step(3'd4, 1'b0, 1'b1, 8'hE0, 8'h00, 8'h00, 1'b0);
      step(3'd4, 1'b0, 1'b1, 8'hAA, 8'h0A, 8'h0A, 1'b0);

      // d5: retimed output, reset mid-pulse, then a full width-3 pulse
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h42, 8'h42, 1'b0);
      step(3'd5, 1'b0, 1'b1, 8'h43, 8'h42, 8'h43, 1'b1);
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h43, 8'h43, 1'b1);
      step(3'd5, 1'b1, 1'b0, 8'h00, 8'h42, 8'h42, 1'b0);
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h42, 8'h42, 1'b0);
      step(3'd5, 1'b0, 1'b1, 8'h43, 8'h42, 8'h43, 1'b1);
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h43, 8'h43, 1'b1);
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h43, 8'h43, 1'b1);
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h43, 8'h42, 1'b0);
      step(3'd5, 1'b0, 1'b0, 8'h00, 8'h42, 8'h42, 1'b0);

      @(negedge clock);
      wr = '0;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
